// File: rtl/riu_pkg.sv
// Shared encodings for the RIU multi-cycle core: opcodes, funct fields,
// ALU operation codes and the control FSM state type.
package riu_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_U = 7'b0110111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/riu_alu_op_decode.sv
// Combinational instruction classifier: maps opcode/funct3/funct7 to the
// ALU operation, operand/write-back selects and a legality flag.
module riu_alu_op_decode
  import riu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       alu_src_imm,
  output logic       wb_sel_imm,
  output logic       legal
);

  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    wb_sel_imm  = 1'b0;
    legal       = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == FUNCT7_BASE) begin
          alu_op = {1'b0, funct3};
          legal  = 1'b1;
        end else if (funct7 == FUNCT7_ALT && funct3 == F3_ADD_SUB) begin
          alu_op = ALU_SUB;
          legal  = 1'b1;
        end else if (funct7 == FUNCT7_ALT && funct3 == F3_SRL_SRA) begin
          alu_op = ALU_SRA;
          legal  = 1'b1;
        end
      end
      OP_I: begin
        alu_src_imm = 1'b1;
        // Only the shift-immediates constrain funct7 (it carries the shift type).
        case (funct3)
          F3_SLL: begin
            alu_op = ALU_SLL;
            legal  = (funct7 == FUNCT7_BASE);
          end
          F3_SRL_SRA: begin
            if (funct7 == FUNCT7_BASE) begin
              alu_op = ALU_SRL;
              legal  = 1'b1;
            end else if (funct7 == FUNCT7_ALT) begin
              alu_op = ALU_SRA;
              legal  = 1'b1;
            end
          end
          default: begin
            alu_op = {1'b0, funct3};
            legal  = 1'b1;
          end
        endcase
      end
      OP_U: begin
        wb_sel_imm = 1'b1;
        legal      = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/riu_multicycle_ctrl.sv
// Multi-cycle control FSM for the RIU core: fetch/decode/execute/write-back
// sequencing, registered ALU controls, sticky illegal flag and retire counter.
module riu_multicycle_ctrl
  import riu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             alu_src_imm,
  output logic             wb_sel_imm,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  state_t     state_next;
  logic [3:0] dec_alu_op;
  logic       dec_src_imm;
  logic       dec_wb_imm;
  logic       dec_legal;

  riu_alu_op_decode u_decode (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_src_imm),
    .wb_sel_imm  (dec_wb_imm),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: state_next = dec_legal ? ST_EXEC : ST_HALT;
      ST_EXEC:   state_next = ST_WB;
      ST_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        state_next = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: busy = 1'b0;
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // ALU controls are captured once in DECODE and held until the next decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op      <= ALU_ADD;
      alu_src_imm <= 1'b0;
      wb_sel_imm  <= 1'b0;
      illegal     <= 1'b0;
      retired     <= '0;
    end else begin
      if (state == ST_DECODE) begin
        if (dec_legal) begin
          alu_op      <= dec_alu_op;
          alu_src_imm <= dec_src_imm;
          wb_sel_imm  <= dec_wb_imm;
        end else begin
          illegal <= 1'b1;
        end
      end
      if (state == ST_WB) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_riu_multicycle_ctrl.sv
// Self-checking bench for riu_multicycle_ctrl: directed sequence plus random
// instructions compared against an instruction-level reference model.
module tb_riu_multicycle_ctrl;

  localparam int CW = 4;
  localparam int RET_MASK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          imem_req;
  logic          imem_ready;
  logic          ir_we;
  logic          pc_we;
  logic          rf_we;
  logic          alu_src_imm;
  logic          wb_sel_imm;
  logic [3:0]    alu_op;
  logic          busy;
  logic          illegal;
  logic [CW-1:0] retired;

  int nChecks = 0;
  int nFails = 0;
  int expRetired = 0;

  riu_multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .rf_we       (rf_we),
    .alu_src_imm (alu_src_imm),
    .wb_sel_imm  (wb_sel_imm),
    .alu_op      (alu_op),
    .busy        (busy),
    .illegal     (illegal),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic [6:0] op,
                               input logic [2:0] f3, input logic [6:0] f7);
    run        = r;
    imem_ready = rdy;
    opcode     = op;
    funct3     = f3;
    funct7     = f7;
  endtask

  // Instruction-level reference: legality and ALU controls from the ISA rules.
  function automatic void expDecode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                    output bit ok, output logic [3:0] aop, output bit srcImm, output bit wbImm);
    ok = 0; aop = 4'd0; srcImm = 0; wbImm = 0;
    if (op == 7'h33) begin
      if (f7 == 7'h00) begin ok = 1; aop = {1'b0, f3}; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; aop = 4'd8; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; aop = 4'd9; end
    end else if (op == 7'h13) begin
      srcImm = 1;
      if (f3 == 3'd1) begin ok = (f7 == 7'h00); aop = 4'd1; end
      else if (f3 == 3'd5) begin
        if (f7 == 7'h00) begin ok = 1; aop = 4'd5; end
        else if (f7 == 7'h20) begin ok = 1; aop = 4'd9; end
      end else begin ok = 1; aop = {1'b0, f3}; end
    end else if (op == 7'h37) begin
      ok = 1; wbImm = 1;
    end
  endfunction

  // Expects to be called at the falling edge of a FETCH cycle; leaves the
  // bench at a FETCH falling edge unless the instruction halts.
  task automatic doInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int stall, input bit runAfter, input bit rstInWb, output bit halted);
    bit ok, eSrc, eWb;
    logic [3:0] eOp;
    expDecode(op, f3, f7, ok, eOp, eSrc, eWb);
    halted = 0;
    for (int i = 0; i < stall; i++) begin
      applyStimulus(1'b1, 1'b0, op, f3, f7);
      #1 checkOutput("fetch_wait", {imem_req, ir_we, rf_we, pc_we, busy}, 5'b10001);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b1, op, f3, f7);
    #1 checkOutput("fetch_ready", {imem_req, ir_we, rf_we, pc_we, busy}, 5'b11001);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, op, f3, f7);
    #1 checkOutput("decode", {imem_req, ir_we, rf_we, pc_we, busy}, 5'b00001);
    @(negedge clk);
    if (!ok) begin
      #1 checkOutput("halt", {imem_req, ir_we, rf_we, pc_we, busy, illegal}, 6'b000001);
      checkOutput("halt_retired", 32'(retired), 32'(expRetired));
      repeat (2) @(negedge clk);
      #1 checkOutput("halt_hold", {imem_req, ir_we, rf_we, pc_we, busy, illegal}, 6'b000001);
      halted = 1;
      return;
    end
    #1 checkOutput("exec", {imem_req, ir_we, rf_we, pc_we, busy, illegal}, 6'b000010);
    checkOutput("exec_ctrl", {alu_op, alu_src_imm, wb_sel_imm}, {eOp, eSrc, eWb});
    applyStimulus(runAfter, 1'b0, op, f3, f7);
    @(negedge clk);
    #1 checkOutput("wb", {imem_req, ir_we, rf_we, pc_we, busy}, 5'b00111);
    checkOutput("wb_ctrl", {alu_op, alu_src_imm, wb_sel_imm}, {eOp, eSrc, eWb});
    if (rstInWb) begin
      rst = 1'b1;
      @(negedge clk);
      #1 checkOutput("wb_reset", {imem_req, ir_we, rf_we, pc_we, busy, illegal, alu_op}, 10'd0);
      checkOutput("wb_reset_retired", 32'(retired), 32'd0);
      expRetired = 0;
      rst = 1'b0;
      run = 1'b1;
      @(negedge clk);
      #1 checkOutput("post_reset_fetch", {imem_req, ir_we, rf_we, pc_we, busy}, 5'b10001);
      return;
    end
    @(negedge clk);
    expRetired = (expRetired + 1) & RET_MASK;
    #1 checkOutput("retired", 32'(retired), 32'(expRetired));
    if (runAfter) begin
      checkOutput("b2b_fetch", {imem_req, rf_we, pc_we, busy}, 4'b1001);
    end else begin
      checkOutput("idle_after_wb", {imem_req, ir_we, rf_we, pc_we, busy}, 5'b00000);
      run = 1'b1;
      @(negedge clk);
      #1 checkOutput("rerun_fetch", {imem_req, ir_we, rf_we, pc_we, busy}, 5'b10001);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    run = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    #1 checkOutput("reset_state", {imem_req, ir_we, rf_we, pc_we, busy, illegal, alu_op, alu_src_imm, wb_sel_imm}, 12'd0);
    checkOutput("reset_retired", 32'(retired), 32'd0);
    expRetired = 0;
    rst = 1'b0;
    run = 1'b1;
    @(negedge clk);
    #1 checkOutput("reset_fetch", {imem_req, ir_we, rf_we, pc_we, busy}, 5'b10001);
  endtask

  initial begin
    bit h;
    logic [6:0] rop, rf7;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 7'h0, 3'h0, 7'h0);
    repeat (2) @(negedge clk);
    #1 checkOutput("init_reset", {imem_req, ir_we, rf_we, pc_we, busy, illegal, alu_op, alu_src_imm, wb_sel_imm}, 12'd0);
    checkOutput("init_retired", 32'(retired), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1 checkOutput("idle_no_run", {imem_req, busy}, 2'b00);
    run = 1'b1;
    @(negedge clk);
    #1 checkOutput("first_fetch", {imem_req, ir_we, busy}, 3'b101);

    doInstr(7'h33, 3'd0, 7'h00, 0, 1, 0, h);   // add
    doInstr(7'h33, 3'd0, 7'h20, 3, 1, 0, h);   // sub, 3 stall cycles
    doInstr(7'h13, 3'd5, 7'h20, 0, 1, 1, h);   // srai, reset during WB
    doInstr(7'h37, 3'd2, 7'h11, 1, 0, 0, h);   // lui, run dropped in EXEC
    doInstr(7'h33, 3'd1, 7'h20, 0, 1, 0, h);   // illegal R
    checkOutput("illegal_r_halted", 32'(h), 32'd1);
    doReset();
    doInstr(7'h63, 3'd0, 7'h00, 0, 1, 0, h);   // branch opcode, unsupported
    checkOutput("illegal_op_halted", 32'(h), 32'd1);
    doReset();

    for (int i = 0; i < 16; i++) doInstr(7'h33, 3'd0, 7'h00, 0, 1, 0, h);
    checkOutput("wrap_zero", 32'(retired), 32'd0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: rop = 7'h33;
        1: rop = 7'h13;
        2: rop = 7'h37;
        default: rop = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1: rf7 = 7'h00;
        2: rf7 = 7'h20;
        default: rf7 = 7'($urandom);
      endcase
      doInstr(rop, 3'($urandom), rf7, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0, h);
      if (h) doReset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
